// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Operands are registered, held for EXEC_CYCLES, then the result is held until taken.
module alu_share_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp0_carry,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,
    output logic       rsp1_carry,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_prio;
    logic           r_gnt;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [SW-1:0]  r_alu_sel;
    logic [DW-1:0]  r_res;
    logic           r_carry;
    logic           w_win;
    logic           w_accept;
    logic           w_rsp_done;

    // Lone requester wins outright; on contention the priority pointer decides.
    always_comb begin
        w_win = r_prio;
        if (req0_valid && !req1_valid) begin
            w_win = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            w_win = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_rsp_done = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is suppressed while reset is held so outputs stay at reset values.
                if (!rst && (req0_valid || req1_valid)) begin
                    w_accept   = 1'b1;
                    req0_ready = ~w_win;
                    req1_ready = w_win;
                    w_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp0_valid = ~r_gnt;
                rsp1_valid = r_gnt;
                w_rsp_done = r_gnt ? rsp1_ready : rsp0_ready;
                if (w_rsp_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, execute counter, result capture and priority hand-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_win ? req1_a   : req0_a;
                r_alu_b   <= w_win ? req1_b   : req0_b;
                r_alu_sel <= w_win ? req1_sel : req0_sel;
                r_gnt     <= w_win;
                r_cnt     <= CW'(EXEC_CYCLES - 1);
            end
            if (r_state == S_EXEC) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_res   <= alu_out;
                    r_carry <= alu_carry;
                end
            end
            if (w_rsp_done) begin
                r_prio <= ~r_gnt;
            end
        end
    end

    assign rsp0_data  = r_res;
    assign rsp0_carry = r_carry;
    assign rsp1_data  = r_res;
    assign rsp1_carry = r_carry;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (EXEC_CYCLES 1 and 4) driven by random
// transactions and checked against a transaction-level arbitration/ALU model.
module tb_alu_share_arbiter;

    localparam int unsigned NI = 2;

    logic       clk = 1'b0;
    logic       rst  [NI];
    logic       rv   [NI][2];
    logic [7:0] ra   [NI][2];
    logic [7:0] rb   [NI][2];
    logic [2:0] rs   [NI][2];
    logic       rrdy [NI][2];
    logic       pv   [NI][2];
    logic       prdy [NI][2];
    logic [7:0] pd   [NI][2];
    logic       pc   [NI][2];
    logic [7:0] aa   [NI];
    logic [7:0] ab   [NI];
    logic [2:0] asel [NI];
    logic [7:0] ao   [NI];
    logic       ac   [NI];
    logic       bsy  [NI];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          prio    [NI];
    logic [18:0] last_op [NI];

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a >= b, 8'(a - b)};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[7], 8'(a << 1)};
            3'd6:    return {a[0], 8'(a >> 1)};
            default: return {1'b0, a};
        endcase
    endfunction

    function automatic int ex_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign {ac[g], ao[g]} = alu_fn(aa[g], ab[g], asel[g]);
        alu_share_arbiter #(.EXEC_CYCLES((g == 0) ? 1 : 4)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0_valid (rv[g][0]),
            .req0_ready (rrdy[g][0]),
            .req0_a     (ra[g][0]),
            .req0_b     (rb[g][0]),
            .req0_sel   (rs[g][0]),
            .req1_valid (rv[g][1]),
            .req1_ready (rrdy[g][1]),
            .req1_a     (ra[g][1]),
            .req1_b     (rb[g][1]),
            .req1_sel   (rs[g][1]),
            .rsp0_valid (pv[g][0]),
            .rsp0_ready (prdy[g][0]),
            .rsp0_data  (pd[g][0]),
            .rsp0_carry (pc[g][0]),
            .rsp1_valid (pv[g][1]),
            .rsp1_ready (prdy[g][1]),
            .rsp1_data  (pd[g][1]),
            .rsp1_carry (pc[g][1]),
            .alu_a      (aa[g]),
            .alu_b      (ab[g]),
            .alu_sel    (asel[g]),
            .alu_out    (ao[g]),
            .alu_carry  (ac[g]),
            .busy       (bsy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drive_rand_ops(input int d);
        for (int r = 0; r < 2; r++) begin
            ra[d][r] = 8'($urandom);
            rb[d][r] = 8'($urandom);
            rs[d][r] = 3'($urandom);
        end
    endtask

    // One complete transaction: grant, execute phase, response with nstall cycles of backpressure.
    task automatic do_txn(input int d, input bit v0, input bit v1, input int nstall,
                          input bit dir, input logic [7:0] da, input logic [7:0] db,
                          input logic [2:0] ds);
        int         w;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] es;
        logic [8:0] res;
        @(negedge clk);
        rv[d][0] = v0;
        rv[d][1] = v1;
        drive_rand_ops(d);
        if (dir) begin
            for (int r = 0; r < 2; r++) begin
                ra[d][r] = da;
                rb[d][r] = db;
                rs[d][r] = ds;
            end
        end
        w = (v0 && v1) ? int'(prio[d]) : (v1 ? 1 : 0);
        prdy[d][w]     = 1'b0;
        prdy[d][1 - w] = 1'($urandom);
        #1;
        check("req_ready", {rrdy[d][1], rrdy[d][0]}, (w == 1) ? 2'b10 : 2'b01);
        check("idle_busy", bsy[d], 1'b0);
        check("idle_rsp_valid", {pv[d][1], pv[d][0]}, 2'b00);
        ea  = ra[d][w];
        eb  = rb[d][w];
        es  = rs[d][w];
        res = alu_fn(ea, eb, es);
        for (int c = 0; c < ex_of(d); c++) begin
            @(negedge clk);
            drive_rand_ops(d);
            #1;
            check("exec_ops", {aa[d], ab[d], asel[d]}, {ea, eb, es});
            check("exec_ready", {rrdy[d][1], rrdy[d][0]}, 2'b00);
            check("exec_rsp_valid", {pv[d][1], pv[d][0]}, 2'b00);
            check("exec_busy", bsy[d], 1'b1);
        end
        for (int s = 0; s <= nstall; s++) begin
            @(negedge clk);
            drive_rand_ops(d);
            if (s == nstall) prdy[d][w] = 1'b1;
            #1;
            check("rsp_valid", {pv[d][1], pv[d][0]}, (w == 1) ? 2'b10 : 2'b01);
            check("rsp_data", pd[d][w], res[7:0]);
            check("rsp_carry", pc[d][w], res[8]);
            check("rsp_req_ready", {rrdy[d][1], rrdy[d][0]}, 2'b00);
            check("rsp_busy", bsy[d], 1'b1);
        end
        @(posedge clk);
        prio[d]    = (w == 0);
        last_op[d] = {ea, eb, es};
    endtask

    task automatic idle_cycle(input int d);
        @(negedge clk);
        rv[d][0] = 1'b0;
        rv[d][1] = 1'b0;
        drive_rand_ops(d);
        #1;
        check("quiet_ready", {rrdy[d][1], rrdy[d][0]}, 2'b00);
        check("quiet_rsp_valid", {pv[d][1], pv[d][0]}, 2'b00);
        check("quiet_busy", bsy[d], 1'b0);
        check("quiet_ops_hold", {aa[d], ab[d], asel[d]}, last_op[d]);
    endtask

    // Accept an operation, then assert reset between edges while it is executing.
    task automatic reset_mid(input int d);
        @(negedge clk);
        rv[d][0] = 1'b1;
        rv[d][1] = 1'($urandom);
        drive_rand_ops(d);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst[d] = 1'b1;
        #1;
        check("arst_busy", bsy[d], 1'b0);
        check("arst_rsp_valid", {pv[d][1], pv[d][0]}, 2'b00);
        check("arst_ops", {aa[d], ab[d], asel[d]}, 19'd0);
        check("arst_ready", {rrdy[d][1], rrdy[d][0]}, 2'b00);
        rv[d][0] = 1'b0;
        rv[d][1] = 1'b0;
        @(negedge clk);
        rst[d]     = 1'b0;
        prio[d]    = 1'b0;
        last_op[d] = '0;
        idle_cycle(d);
        idle_cycle(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        for (int d = 0; d < NI; d++) begin
            rst[d]     = 1'b1;
            prio[d]    = 1'b0;
            last_op[d] = '0;
            for (int r = 0; r < 2; r++) begin
                rv[d][r]   = 1'b1;
                prdy[d][r] = 1'b0;
            end
            drive_rand_ops(d);
        end
        #12;
        for (int d = 0; d < NI; d++) begin
            check("reset_ready", {rrdy[d][1], rrdy[d][0]}, 2'b00);
            check("reset_rsp_valid", {pv[d][1], pv[d][0]}, 2'b00);
            check("reset_busy", bsy[d], 1'b0);
            check("reset_ops", {aa[d], ab[d], asel[d]}, 19'd0);
            check("reset_rsp", {pd[d][0], pc[d][0]}, 9'd0);
            rv[d][0] = 1'b0;
            rv[d][1] = 1'b0;
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        do_txn(0, 1'b1, 1'b0, 0, 1'b1, 8'h3C, 8'h0A, 3'd0);
        idle_cycle(0);
        do_txn(0, 1'b0, 1'b1, 0, 1'b1, 8'hF0, 8'h20, 3'd0);
        do_txn(0, 1'b1, 1'b0, 0, 1'b1, 8'h10, 8'h20, 3'd1);
        do_txn(0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00, 3'd0);
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00, 3'd0);
        do_txn(0, 1'b1, 1'b1, 5, 1'b0, 8'h00, 8'h00, 3'd0);
        do_txn(0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00, 3'd0);
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(1, 3);
            do_txn(0, 1'((v >> 0) & 1), 1'((v >> 1) & 1), $urandom_range(0, 3),
                   1'b0, 8'h00, 8'h00, 3'd0);
            if ($urandom_range(0, 3) == 0) idle_cycle(0);
        end
        reset_mid(0);
        do_txn(0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00, 3'd0);

        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(1, 3);
            do_txn(1, 1'((v >> 0) & 1), 1'((v >> 1) & 1), $urandom_range(0, 2),
                   1'b0, 8'h00, 8'h00, 3'd0);
        end
        reset_mid(1);
        do_txn(1, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
